// File: rtl/core_run_controller.sv
// core_run_controller: host load/run/step/halt/breakpoint control and cycle counting for the single-cycle RV64 core
module core_run_controller #(
  parameter int XLEN = 64,
  parameter int IMEM_WORDS = 256,
  parameter int CYCLE_W = 32,
  parameter int RESET_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [XLEN-1:0]    cmd_addr,
  input  logic [31:0]        cmd_data,
  input  logic [XLEN-1:0]    pc,
  input  logic [31:0]        instruction,
  output logic               core_enable,
  output logic               core_reset,
  output logic               imem_we,
  output logic [XLEN-1:0]    imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               halted,
  output logic [1:0]         halt_cause,
  output logic               cmd_error,
  output logic [CYCLE_W-1:0] cycle_count
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam logic [2:0] OP_LOAD = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3, OP_HALT = 3'd4;
  localparam logic [2:0] OP_SET = 3'd5, OP_CLR = 3'd6, OP_RESTART = 3'd7;
  typedef enum logic [2:0] {RST_HOLD, IDLE, LOAD, RUN, STEP} state_t;
  state_t state, state_n;
  logic [HW-1:0] hold_cnt;
  logic [XLEN-1:0] bkpt_addr, load_addr;
  logic [31:0] load_data;
  logic bkpt_valid, skip_bkpt, ebreak, bkpt_hit, stop, accept, load_ok, err_n;
  logic [1:0] cause_n;
  assign cmd_ready = state == IDLE || state == RUN;
  assign accept = cmd_valid && cmd_ready;
  assign load_ok = cmd_addr[1:0] == 2'b00 && cmd_addr < XLEN'(IMEM_WORDS * 4);
  assign ebreak = instruction == 32'h0010_0073;
  assign bkpt_hit = bkpt_valid && pc == bkpt_addr && !skip_bkpt;
  assign stop = ebreak || bkpt_hit;
  assign core_enable = (state == RUN || state == STEP) && !stop;
  assign core_reset = state == RST_HOLD;
  assign halted = state == IDLE;
  assign imem_we = state == LOAD;
  assign imem_waddr = load_addr;
  assign imem_wdata = load_data;
  always_comb begin
    state_n = state;
    cause_n = halt_cause;
    err_n = 1'b0;
    case (state)
      RST_HOLD: state_n = hold_cnt == HW'(1) ? IDLE : RST_HOLD;
      LOAD: state_n = IDLE;
      STEP: begin
        state_n = IDLE;
        cause_n = core_enable ? 2'd1 : 2'd2;
      end
      IDLE: if (accept)
        case (cmd_op)
          OP_LOAD: if (load_ok) state_n = LOAD; else err_n = 1'b1;
          OP_RUN: state_n = RUN;
          OP_STEP: state_n = STEP;
          default: state_n = IDLE;
        endcase
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          cause_n = ebreak ? 2'd2 : 2'd3;
        end else if (accept && cmd_op == OP_HALT) begin
          state_n = IDLE;
          cause_n = 2'd1;
        end
        err_n = accept && (cmd_op == OP_LOAD || cmd_op == OP_RUN || cmd_op == OP_STEP);
      end
      default: state_n = RST_HOLD;
    endcase
    if (accept && cmd_op == OP_RESTART) state_n = RST_HOLD;
    if (state_n != state && state_n inside {RUN, STEP, RST_HOLD}) cause_n = 2'd0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RST_HOLD;
      hold_cnt <= HW'(RESET_CYCLES);
      halt_cause <= 2'd0;
      cmd_error <= 1'b0;
      cycle_count <= '0;
      bkpt_valid <= 1'b0;
      skip_bkpt <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= state == RST_HOLD ? hold_cnt - 1'b1 : HW'(RESET_CYCLES);
      halt_cause <= cause_n;
      cmd_error <= err_n;
      skip_bkpt <= state == IDLE;
      if (accept && cmd_op == OP_RESTART) cycle_count <= '0;
      else if (core_enable && !(&cycle_count)) cycle_count <= cycle_count + 1'b1;
      if (accept && cmd_op == OP_SET) bkpt_valid <= 1'b1;
      if (accept && cmd_op == OP_CLR) bkpt_valid <= 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (accept && cmd_op == OP_SET) bkpt_addr <= cmd_addr;
    if (state == IDLE && accept && cmd_op == OP_LOAD) begin
      load_addr <= cmd_addr;
      load_data <= cmd_data;
    end
  end
endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller: scoreboard bench driving the controller against a small core/imem model
module tb_core_run_controller;
  logic clock = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [63:0] cmd_addr = 64'd0, pc, imem_waddr;
  logic [31:0] cmd_data = 32'd0, instruction, imem_wdata, cycle_count;
  logic cmd_ready, core_enable, core_reset, imem_we, halted, cmd_error;
  logic [1:0] halt_cause;
  logic [31:0] imem [256];
  int checks = 0, errors = 0;
  typedef struct {logic [63:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [63:0] pc; logic [1:0] cause; logic [31:0] cnt;} hlt_t;
  wr_t wq[$];
  hlt_t hq[$];
  core_run_controller dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .pc(pc),
    .instruction(instruction), .core_enable(core_enable), .core_reset(core_reset),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .halted(halted), .halt_cause(halt_cause), .cmd_error(cmd_error), .cycle_count(cycle_count)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (core_reset) pc <= 64'd0; else if (core_enable) pc <= pc + 64'd4;
  always @(posedge clock) if (imem_we) imem[imem_waddr[9:2]] <= imem_wdata;
  assign instruction = imem[pc[9:2]];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clock) if (imem_we) begin
    wr_t e;
    check("we_expected", 64'(wq.size() > 0), 64'd1);
    if (wq.size() > 0) begin
      e = wq.pop_front();
      check("we_addr", imem_waddr, e.a);
      check("we_data", 64'(imem_wdata), 64'(e.d));
    end
  end
  task automatic send(input logic [2:0] op, input logic [63:0] a = 64'd0, input logic [31:0] d = 32'd0);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
  endtask
  task automatic load(input logic [63:0] a, input logic [31:0] d, input logic ok);
    if (ok) wq.push_back('{a, d});
    send(3'd1, a, d);
    check("ld_err", 64'(cmd_error), 64'(!ok));
    check("ld_we", 64'(imem_we), 64'(ok));
    @(negedge clock);
    check("ld_we_one", 64'(imem_we), 64'd0);
  endtask
  task automatic expect_halt(input logic [63:0] p, input logic [1:0] c, input logic [31:0] n);
    hq.push_back('{p, c, n});
  endtask
  task automatic wait_halt(input string tag);
    hlt_t e;
    int n = 0;
    while (!halted && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_halted"}, 64'(halted), 64'd1);
    e = hq.pop_front();
    check({tag, "_pc"}, pc, e.pc);
    check({tag, "_cause"}, 64'(halt_cause), 64'(e.cause));
    check({tag, "_count"}, 64'(cycle_count), 64'(e.cnt));
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clock);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_enable", 64'(core_enable), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_err", 64'(cmd_error), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    reset = 1'b0;
    n = 0;
    while (core_reset && n < 10) begin
      n++;
      @(negedge clock);
    end
    check("rst_len", 64'(n), 64'd2);
    check("idle_halted", 64'(halted), 64'd1);
    check("idle_ready", 64'(cmd_ready), 64'd1);
    check("idle_count", 64'(cycle_count), 64'd0);
    check("idle_cause", 64'(halt_cause), 64'd0);
    load(64'h0, 32'h0050_0093, 1'b1);
    load(64'h4, 32'h0000_0013, 1'b1);
    load(64'h8, 32'h0010_0073, 1'b1);
    load(64'h402, 32'h0000_0013, 1'b0);
    load(64'h400, 32'h0000_0013, 1'b0);
    check("err_pulse", 64'(cmd_error), 64'd0);
    expect_halt(64'h8, 2'd2, 32'd2);
    send(3'd2);
    wait_halt("run_ebreak");
    expect_halt(64'h8, 2'd2, 32'd2);
    send(3'd2);
    wait_halt("run_again");
    send(3'd5, 64'h4);
    send(3'd7);
    expect_halt(64'h4, 2'd3, 32'd1);
    send(3'd2);
    wait_halt("run_bkpt");
    expect_halt(64'h8, 2'd2, 32'd2);
    send(3'd2);
    wait_halt("run_skip_bkpt");
    send(3'd6);
    for (int k = 0; k < 9; k++) load(64'(k * 4), 32'h0000_0013, 1'b1);
    send(3'd7);
    for (int k = 1; k <= 3; k++) begin
      expect_halt(64'(k * 4), 2'd1, 32'(k));
      send(3'd3);
      check("step_ready", 64'(cmd_ready), 64'd0);
      check("step_enable", 64'(core_enable), 64'd1);
      wait_halt("step");
    end
    expect_halt(64'd16, 2'd1, 32'd4);
    send(3'd2);
    send(3'd4);
    wait_halt("run_halt");
    expect_halt(64'd24, 2'd1, 32'd6);
    send(3'd2);
    send(3'd1, 64'h40, 32'h0000_0013);
    check("run_ld_err", 64'(cmd_error), 64'd1);
    check("run_ld_we", 64'(imem_we), 64'd0);
    send(3'd4);
    wait_halt("run_ld");
    force dut.cycle_count = 32'hFFFF_FFFE;
    @(negedge clock);
    release dut.cycle_count;
    @(negedge clock);
    check("force_count", 64'(cycle_count), 64'hFFFF_FFFE);
    expect_halt(64'd36, 2'd1, 32'hFFFF_FFFF);
    send(3'd2);
    repeat (2) @(negedge clock);
    send(3'd4);
    wait_halt("saturate");
    wq.push_back('{64'h24, 32'h0000_0013});
    send(3'd1, 64'h24, 32'h0000_0013);
    check("pre_rst_we", 64'(imem_we), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_we", 64'(imem_we), 64'd0);
    check("mid_rst_core_reset", 64'(core_reset), 64'd1);
    check("mid_rst_halted", 64'(halted), 64'd0);
    check("mid_rst_cause", 64'(halt_cause), 64'd0);
    check("mid_rst_count", 64'(cycle_count), 64'd0);
    reset = 1'b0;
    n = 0;
    while (!halted && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("post_rst_halted", 64'(halted), 64'd1);
    check("wq_empty", 64'(wq.size()), 64'd0);
    check("hq_empty", 64'(hq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
